sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter NUM_SPR, default 2, number of sprite channels (1..4).
REQ-002 SHALL have parameter SPR_W, default 110, sprite width in pixels.
REQ-003 SHALL have parameter SPR_H, default 86, sprite height in pixels.
REQ-004 SHALL have parameter FRAMES, default 4, animation frames per sprite ROM; FRAME_BITS = clog2(FRAMES).
REQ-005 SHALL have parameter ROM_LAT, default 1, sprite/background ROM read latency in cycles (1..2).
REQ-006 SHALL have parameter KEY_RGB, default 12'h6AF, transparent colour key.
REQ-007 SHALL derive localparam ADDR_W = clog2(FRAMES*SPR_W*SPR_H).
REQ-008 SHALL have vga_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-009 SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have DrawX and DrawY, input, 10 each, current pixel coordinate.
REQ-011 SHALL have blank, input, 1, 1 = active video, 0 = blanking.
REQ-012 SHALL have spr_x and spr_y, input, NUM_SPR*10 each, sprite top-left coordinates; channel i at bits [10i+9:10i].
REQ-013 SHALL have spr_en, input, NUM_SPR, per-sprite enable.
REQ-014 SHALL have spr_frame, input, NUM_SPR*FRAME_BITS, animation frame select per sprite.
REQ-015 SHALL have spr_addr, output, NUM_SPR*ADDR_W, ROM address per sprite.
REQ-016 SHALL have spr_rgb, input, NUM_SPR*12, palette-resolved ROM pixel per sprite ({R,G,B}).
REQ-017 SHALL have bg_rgb, input, 12, background pixel, aligned with spr_rgb.
REQ-018 SHALL have collision_clr, input, 1, single-cycle clear of collision flag.
REQ-019 SHALL have Red, Green, Blue, output, 4 each, registered pixel colour.
REQ-020 SHALL have collision, output, 1, sticky sprite-overlap flag.

Function
REQ-021 Hit for sprite i SHALL be spr_en[i] && X<=DrawX<X+SPR_W && Y<=DrawY<Y+SPR_H, compared in 11 bits so X+SPR_W never wraps.
REQ-022 Stage 0 SHALL register spr_addr[i] = spr_frame[i]*SPR_W*SPR_H + (DrawY-Y)*SPR_W + (DrawX-X) on hit, else hold 0.
REQ-023 Hit vector and blank SHALL be delayed by a shift register of ROM_LAT+1 stages to align with spr_rgb/bg_rgb.
REQ-024 spr_rgb and bg_rgb SHALL be sampled ROM_LAT cycles after spr_addr is registered.
REQ-025 Total latency DrawX/DrawY/blank -> Red/Green/Blue SHALL be exactly ROM_LAT+2 cycles.
REQ-026 Sprite i SHALL be opaque at a pixel when its aligned hit is 1 and spr_rgb[i] != KEY_RGB (full 12-bit compare).
REQ-027 Output colour SHALL be the lowest-index opaque sprite; if none, bg_rgb.
REQ-028 When aligned blank = 0, output register SHALL load 0,0,0 regardless of hits.
REQ-029 collision SHALL set when two or more sprites are opaque at the same aligned pixel with aligned blank = 1.
REQ-030 collision SHALL clear on collision_clr; simultaneous set and clear SHALL leave collision = 1.
REQ-031 Coordinates or frame changing mid-line SHALL take effect on the next pixel, with no hold-off.
REQ-032 spr_frame >= FRAMES SHALL be treated as frame 0.

Reset
REQ-033 reset_n = 0 SHALL asynchronously clear Red, Green, Blue, spr_addr, collision, and all delay-line and hit state to 0.
REQ-034 After reset_n deasserts, the first ROM_LAT+2 outputs SHALL be black, because the pipeline holds blank = 0.
REQ-035 Reset asserted mid-frame SHALL take effect immediately, with no partial pixel output.

Verification
REQ-036 Set NUM_SPR=2, ROM_LAT=1, sprite0 at (100,50), spr_rgb0=12'hF00, blank=1, DrawX=100, DrawY=50 at cycle t -> spr_addr0=0 at t+1 and Red/Green/Blue=F,0,0 at t+3.
REQ-037 Drive DrawX=210 (X+SPR_W), DrawY=50 -> no hit and output = bg_rgb; drive DrawX=209 -> hit with spr_addr0=109.
REQ-038 Overlap sprite0 and sprite1 with both opaque (12'h0F0, 12'h00F) -> output 0,F,0 and collision=1; then make sprite0 = KEY_RGB -> output 0,0,F and collision stays 1 until collision_clr.
REQ-039 Set spr_frame0=2, sprite0 at (0,0), DrawX=1, DrawY=1 -> spr_addr0 = 2*9460+110+1 = 19031.
REQ-040 Pulse blank=0 for one pixel inside a sprite -> exactly one black output pixel, ROM_LAT+2 cycles later.
REQ-041 Assert reset_n=0 mid-line with collision=1 -> all outputs 0 within the same cycle, asynchronously; after release, ROM_LAT+2 black outputs.

Source files
------------

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: computes per-sprite ROM addresses from the scan position,
// waits out the ROM latency, then picks the lowest-index opaque sprite over the background.
module sprite_compositor #(
  parameter int          NUM_SPR    = 2,
  parameter int          SPR_W      = 110,
  parameter int          SPR_H      = 86,
  parameter int          FRAMES     = 4,
  parameter int          ROM_LAT    = 1,
  parameter logic [11:0] KEY_RGB    = 12'h6AF,
  localparam int         FRAME_BITS = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int         ADDR_W     = $clog2(FRAMES * SPR_W * SPR_H)
) (
  input  logic                           vga_clk,
  input  logic                           reset_n,
  input  logic [9:0]                     DrawX,
  input  logic [9:0]                     DrawY,
  input  logic                           blank,
  input  logic [NUM_SPR*10-1:0]          spr_x,
  input  logic [NUM_SPR*10-1:0]          spr_y,
  input  logic [NUM_SPR-1:0]             spr_en,
  input  logic [NUM_SPR*FRAME_BITS-1:0]  spr_frame,
  output logic [NUM_SPR*ADDR_W-1:0]      spr_addr,
  input  logic [NUM_SPR*12-1:0]          spr_rgb,
  input  logic [11:0]                    bg_rgb,
  input  logic                           collision_clr,
  output logic [3:0]                     Red,
  output logic [3:0]                     Green,
  output logic [3:0]                     Blue,
  output logic                           collision
);

  localparam int FRAME_PIX = SPR_W * SPR_H;

  logic [NUM_SPR-1:0]                 hit_d;
  logic [NUM_SPR-1:0][FRAME_BITS-1:0] frame_sel;
  logic [NUM_SPR-1:0][ADDR_W-1:0]     addr_d, addr_q;
  logic [ROM_LAT:0][NUM_SPR-1:0]      hit_pipe_q;
  logic [ROM_LAT:0]                   blank_pipe_q;
  logic [NUM_SPR-1:0]                 hit_al, opaque;
  logic                               blank_al;
  logic [11:0]                        pix, rgb_d, rgb_q;
  logic                               seen, multi, col_d, col_q;

  // Stage 0: hit test in 11 bits so X+SPR_W cannot wrap; out-of-range frames fall back to 0.
  always_comb begin
    hit_d     = '0;
    frame_sel = '0;
    addr_d    = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      hit_d[i] = spr_en[i]
        && ({1'b0, DrawX} >= {1'b0, spr_x[10*i +: 10]})
        && ({1'b0, DrawX} <  ({1'b0, spr_x[10*i +: 10]} + 11'(SPR_W)))
        && ({1'b0, DrawY} >= {1'b0, spr_y[10*i +: 10]})
        && ({1'b0, DrawY} <  ({1'b0, spr_y[10*i +: 10]} + 11'(SPR_H)));
      if (int'(spr_frame[FRAME_BITS*i +: FRAME_BITS]) < FRAMES)
        frame_sel[i] = spr_frame[FRAME_BITS*i +: FRAME_BITS];
      if (hit_d[i])
        addr_d[i] = ADDR_W'(frame_sel[i]) * ADDR_W'(FRAME_PIX)
                  + ADDR_W'(DrawY - spr_y[10*i +: 10]) * ADDR_W'(SPR_W)
                  + ADDR_W'(DrawX - spr_x[10*i +: 10]);
    end
  end

  assign hit_al   = hit_pipe_q[ROM_LAT];
  assign blank_al = blank_pipe_q[ROM_LAT];

  // Descending scan so the lowest-index opaque sprite is the last writer of pix.
  always_comb begin
    opaque = '0;
    pix    = bg_rgb;
    seen   = 1'b0;
    multi  = 1'b0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      opaque[i] = hit_al[i] && (spr_rgb[12*i +: 12] != KEY_RGB);
      if (opaque[i]) begin
        pix = spr_rgb[12*i +: 12];
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    rgb_d = blank_al ? pix : 12'h000;
    col_d = (blank_al && multi) || (col_q && !collision_clr);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      hit_pipe_q   <= '0;
      blank_pipe_q <= '0;
      rgb_q        <= '0;
      col_q        <= 1'b0;
    end else begin
      addr_q          <= addr_d;
      hit_pipe_q[0]   <= hit_d;
      blank_pipe_q[0] <= blank;
      for (int s = 1; s <= ROM_LAT; s++) begin
        hit_pipe_q[s]   <= hit_pipe_q[s-1];
        blank_pipe_q[s] <= blank_pipe_q[s-1];
      end
      rgb_q <= rgb_d;
      col_q <= col_d;
    end
  end

  assign spr_addr  = addr_q;
  assign Red       = rgb_q[11:8];
  assign Green     = rgb_q[7:4];
  assign Blue      = rgb_q[3:0];
  assign collision = col_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed vector table, hand-written corner sequences, and
// randomized scanning checked each cycle against a pixel-rule reference model.
module tb_sprite_compositor;

  localparam int          NUM_SPR = 2;
  localparam int          SPR_W   = 110;
  localparam int          SPR_H   = 86;
  localparam int          FRAMES  = 3;
  localparam int          ROM_LAT = 1;
  localparam logic [11:0] KEY     = 12'h6AF;
  localparam int          AW      = 15;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [19:0] spr_x, spr_y;
  logic [1:0]  spr_en;
  logic [3:0]  spr_frame;
  logic [29:0] spr_addr;
  logic [23:0] spr_rgb;
  logic [11:0] bg_rgb;
  logic        collision_clr;
  logic [3:0]  Red, Green, Blue;
  logic        collision;

  logic [1:0]  ovr_en;
  logic [23:0] ovr_val;
  logic        bg_ovr;
  logic [11:0] bg_val;
  logic [23:0] rom_q = '0;
  logic [11:0] bg_q1 = '0, bg_q2 = '0;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;
  bit exp_col = 1'b0;

  sprite_compositor #(
    .NUM_SPR(NUM_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES),
    .ROM_LAT(ROM_LAT), .KEY_RGB(KEY)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_frame(spr_frame),
    .spr_addr(spr_addr), .spr_rgb(spr_rgb), .bg_rgb(bg_rgb), .collision_clr(collision_clr),
    .Red(Red), .Green(Green), .Blue(Blue), .collision(collision)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [11:0] rom_hash(int i, int a);
    if (((a + 3 * i) % 5) == 0) return KEY;
    return 12'(a * 37 + i * 1111 + 5);
  endfunction

  function automatic logic [11:0] bg_hash(int x, int y);
    return 12'(x * 7 + y * 13 + 1);
  endfunction

  // Sprite ROMs (one-cycle latency) and a background source delayed to match.
  always @(posedge vga_clk) begin
    for (int i = 0; i < NUM_SPR; i++)
      rom_q[12*i +: 12] <= ovr_en[i] ? ovr_val[12*i +: 12] : rom_hash(i, int'(spr_addr[AW*i +: AW]));
    bg_q1 <= bg_ovr ? bg_val : bg_hash(int'(DrawX), int'(DrawY));
    bg_q2 <= bg_q1;
  end
  assign spr_rgb = rom_q;
  assign bg_rgb  = bg_q2;

  typedef struct {
    int x; int y; bit blank;
    logic [19:0] sx; logic [19:0] sy; logic [1:0] en; logic [3:0] fr;
    logic [1:0] oen; logic [23:0] oval; bit bgo; logic [11:0] bgv;
    bit clr; bit rst;
  } hist_t;
  hist_t hist [0:8191];

  function automatic bit hit_of(hist_t h, int i);
    int sx, sy;
    sx = int'(h.sx[10*i +: 10]);
    sy = int'(h.sy[10*i +: 10]);
    return h.en[i] && h.x >= sx && h.x < sx + SPR_W && h.y >= sy && h.y < sy + SPR_H;
  endfunction

  function automatic int addr_of(hist_t h, int i);
    int f;
    f = int'(h.fr[2*i +: 2]);
    if (f >= FRAMES) f = 0;
    return f * SPR_W * SPR_H + (h.y - int'(h.sy[10*i +: 10])) * SPR_W + (h.x - int'(h.sx[10*i +: 10]));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
    end
  endtask

  // Pixel rules: input at edge j sets spr_addr after edge j; colour/collision after edge j+2.
  task automatic check_edge();
    hist_t h0, h1, h2;
    logic [11:0] pix, v;
    logic [11:0] opq[$];
    h0 = hist[k];
    if (h0.rst) begin
      exp_col = 1'b0;
      chk("rst_rgb", {20'h0, Red, Green, Blue}, 32'h0);
      chk("rst_col", {31'h0, collision}, 32'h0);
      chk("rst_addr", {2'b0, spr_addr}, 32'h0);
      return;
    end
    for (int i = 0; i < NUM_SPR; i++)
      chk($sformatf("addr%0d", i), {17'h0, spr_addr[AW*i +: AW]},
          hit_of(h0, i) ? 32'(addr_of(h0, i)) : 32'h0);
    h2 = hist[k-2];
    h1 = hist[k-1];
    for (int i = 0; i < NUM_SPR; i++) begin
      if (hit_of(h2, i)) begin
        v = h1.oen[i] ? h1.oval[12*i +: 12] : rom_hash(i, addr_of(h2, i));
        if (v != KEY) opq.push_back(v);
      end
    end
    pix = (opq.size() > 0) ? opq[0] : (h2.bgo ? h2.bgv : bg_hash(h2.x, h2.y));
    if (!h2.blank) pix = 12'h000;
    if (h2.blank && opq.size() >= 2) exp_col = 1'b1;
    else if (h0.clr) exp_col = 1'b0;
    chk("rgb", {20'h0, Red, Green, Blue}, {20'h0, pix});
    chk("collision", {31'h0, collision}, {31'h0, exp_col});
  endtask

  task automatic step();
    @(posedge vga_clk);
    hist[k].x = int'(DrawX); hist[k].y = int'(DrawY);
    hist[k].rst = !reset_n;
    hist[k].blank = blank && reset_n;
    hist[k].en = reset_n ? spr_en : 2'b00;
    hist[k].sx = spr_x; hist[k].sy = spr_y; hist[k].fr = spr_frame;
    hist[k].oen = ovr_en; hist[k].oval = ovr_val;
    hist[k].bgo = bg_ovr; hist[k].bgv = bg_val; hist[k].clr = collision_clr;
    #1;
    check_edge();
    k++;
    @(negedge vga_clk);
  endtask

  typedef struct {
    int x; int y; bit blank;
    int sx0; int sy0; int sx1; int sy1;
    logic [1:0] en; int fr0;
    logic [11:0] o0; logic [11:0] o1;
    int exp_addr0; logic [11:0] exp_rgb;
  } vec_t;

  initial begin
    vec_t vecs[14];
    int nblack, pos;

    vecs[0]  = '{100, 50, 1'b1, 100, 50, 300, 300, 2'b01, 0, 12'hF00, 12'h00F, 0,     12'hF00};
    vecs[1]  = '{210, 50, 1'b1, 100, 50, 300, 300, 2'b01, 0, 12'hF00, 12'h00F, 0,     12'h123};
    vecs[2]  = '{209, 50, 1'b1, 100, 50, 300, 300, 2'b01, 0, 12'hF00, 12'h00F, 109,   12'hF00};
    vecs[3]  = '{99,  50, 1'b1, 100, 50, 300, 300, 2'b01, 0, 12'hF00, 12'h00F, 0,     12'h123};
    vecs[4]  = '{100, 135, 1'b1, 100, 50, 300, 300, 2'b01, 0, 12'hF00, 12'h00F, 9350, 12'hF00};
    vecs[5]  = '{100, 136, 1'b1, 100, 50, 300, 300, 2'b01, 0, 12'hF00, 12'h00F, 0,    12'h123};
    vecs[6]  = '{1,   1,  1'b1, 0,   0,  300, 300, 2'b01, 2, 12'hF00, 12'h00F, 19031, 12'hF00};
    vecs[7]  = '{1,   1,  1'b1, 0,   0,  300, 300, 2'b01, 3, 12'hF00, 12'h00F, 111,   12'hF00};
    vecs[8]  = '{105, 55, 1'b1, 100, 50, 100, 50,  2'b11, 0, 12'h0F0, 12'h00F, 555,   12'h0F0};
    vecs[9]  = '{105, 55, 1'b1, 100, 50, 100, 50,  2'b11, 0, KEY,     12'h00F, 555,   12'h00F};
    vecs[10] = '{105, 55, 1'b1, 100, 50, 100, 50,  2'b10, 0, 12'h0F0, 12'h00F, 0,     12'h00F};
    vecs[11] = '{105, 55, 1'b0, 100, 50, 100, 50,  2'b11, 0, 12'h0F0, 12'h00F, 555,   12'h000};
    vecs[12] = '{105, 55, 1'b1, 100, 50, 100, 50,  2'b11, 0, KEY,     KEY,     555,   12'h123};
    vecs[13] = '{1023, 50, 1'b1, 1000, 50, 300, 300, 2'b01, 0, 12'hF00, 12'h00F, 23,  12'hF00};

    reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0; spr_x = '0; spr_y = '0;
    spr_en = '0; spr_frame = '0; collision_clr = 1'b0;
    ovr_en = 2'b11; ovr_val = '0; bg_ovr = 1'b1; bg_val = 12'h123;
    repeat (3) step();
    reset_n = 1'b1;

    // Directed vector table
    for (int n = 0; n < 14; n++) begin
      DrawX = 10'(vecs[n].x); DrawY = 10'(vecs[n].y); blank = vecs[n].blank;
      spr_x = {10'(vecs[n].sx1), 10'(vecs[n].sx0)};
      spr_y = {10'(vecs[n].sy1), 10'(vecs[n].sy0)};
      spr_en = vecs[n].en; spr_frame = {2'd0, 2'(vecs[n].fr0)};
      ovr_val = {vecs[n].o1, vecs[n].o0};
      step();
      chk($sformatf("tbl%0d_addr0", n), {17'h0, spr_addr[AW-1:0]}, 32'(vecs[n].exp_addr0));
      step(); step();
      chk($sformatf("tbl%0d_rgb", n), {20'h0, Red, Green, Blue}, {20'h0, vecs[n].exp_rgb});
    end

    // Collision stays set after the overlap vanished, until a clear pulse.
    chk("col_sticky", {31'h0, collision}, 32'h1);
    collision_clr = 1'b1; step(); collision_clr = 1'b0;
    chk("col_cleared", {31'h0, collision}, 32'h0);

    // Set and clear together: set wins.
    spr_x = {10'd100, 10'd100}; spr_y = {10'd50, 10'd50}; spr_en = 2'b11;
    ovr_val = {12'h00F, 12'h0F0}; DrawX = 10'd120; DrawY = 10'd60; blank = 1'b1;
    collision_clr = 1'b1;
    repeat (4) step();
    chk("col_set_wins", {31'h0, collision}, 32'h1);
    collision_clr = 1'b0;

    // Single blanked pixel inside a sprite gives exactly one black output, two cycles on.
    spr_en = 2'b01; ovr_val = {12'h00F, 12'hF00};
    repeat (4) step();
    collision_clr = 1'b1; step(); collision_clr = 1'b0;
    nblack = 0; pos = -1;
    blank = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      blank = 1'b1;
      if ({Red, Green, Blue} == 12'h000) begin nblack++; pos = j; end
    end
    chk("blank_pulse_count", 32'(nblack), 32'd1);
    chk("blank_pulse_pos", 32'(pos), 32'd2);

    // Asynchronous reset mid-line with collision set.
    spr_en = 2'b11; ovr_val = {12'h00F, 12'h0F0};
    repeat (4) step();
    chk("pre_rst_col", {31'h0, collision}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rgb", {20'h0, Red, Green, Blue}, 32'h0);
    chk("async_col", {31'h0, collision}, 32'h0);
    chk("async_addr", {2'b0, spr_addr}, 32'h0);
    step(); step();
    reset_n = 1'b1;
    #1 chk("post_rst_black0", {20'h0, Red, Green, Blue}, 32'h0);
    step();
    chk("post_rst_black1", {20'h0, Red, Green, Blue}, 32'h0);
    step();
    chk("post_rst_black2", {20'h0, Red, Green, Blue}, 32'h0);
    step();
    chk("post_rst_pixel", {20'h0, Red, Green, Blue}, 32'h0F0);

    // Randomized scanning with mid-line sprite/frame changes.
    ovr_en = 2'b00; bg_ovr = 1'b0; DrawX = '0; DrawY = 10'd60;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < NUM_SPR; i++) begin
          spr_x[10*i +: 10] = 10'($urandom_range(0, 250));
          spr_y[10*i +: 10] = 10'($urandom_range(0, 200));
          ovr_val[12*i +: 12] = ($urandom_range(0, 1) == 0) ? KEY : 12'($urandom);
        end
        spr_en = 2'($urandom_range(0, 3));
        spr_frame = 4'($urandom);
        ovr_en = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      end
      if (DrawX >= 10'd319) begin
        DrawX = '0;
        DrawY = 10'($urandom_range(0, 300));
      end else begin
        DrawX = DrawX + 10'd1;
      end
      blank = ($urandom_range(0, 9) != 0);
      collision_clr = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
